// File: rtl/dram_pkg.sv
// Shared DRAM command encodings, refresh FSM state encodings and default timing.
// Used by refresh_scheduler and its down_timer.
package dram_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'b00,
        PREA = 2'b01,
        REF  = 2'b10
    } cmd_t;

    typedef enum logic [2:0] {
        RS_IDLE     = 3'd0,
        RS_REQ      = 3'd1,
        RS_PREA     = 3'd2,
        RS_WAIT_RP  = 3'd3,
        RS_REF      = 3'd4,
        RS_WAIT_RFC = 3'd5
    } ref_state_t;

    localparam int T_RP_DEF  = 3;
    localparam int T_RFC_DEF = 44;

    // Command driven on the bus while the refresh FSM sits in a given state.
    function automatic logic [1:0] cmd_for_state(input logic [2:0] st);
        case (st)
            RS_PREA: return PREA;
            RS_REF:  return REF;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter that stops at zero; zero is high whenever the count is 0.
module down_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(1);

    logic [W-1:0] count_r;

    // Load wins over counting; the count holds at zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != CNT_ZERO) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/refresh_scheduler.sv
// Turns refresh ticks into PREA/REF sequences on the command bus, tracking owed refreshes.
// Optional macro REFRESH_BURST_EN: chain REFs without re-precharging while refreshes remain owed.
module refresh_scheduler
    import dram_pkg::*;
#(
    parameter int MAX_POSTPONE = 8,
    parameter int T_RP         = T_RP_DEF,
    parameter int T_RFC        = T_RFC_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                refresh_flag,
    input  logic                                ref_gnt,
    input  logic                                cmd_ready,
    output logic                                ref_req,
    output logic                                ref_urgent,
    output logic                                cmd_valid,
    output logic [1:0]                          cmd_code,
    output logic [$clog2(MAX_POSTPONE+2)-1:0]   pending,
    output logic                                ref_busy,
    output logic                                overflow
);

    localparam int PW = $clog2(MAX_POSTPONE + 2);
    localparam int TW = (T_RFC > 1) ? $clog2(T_RFC) : 1;

    localparam logic [PW-1:0] PEND_SAT  = PW'(MAX_POSTPONE + 1);
    localparam logic [PW-1:0] PEND_URG  = PW'(MAX_POSTPONE);
    localparam logic [PW-1:0] PEND_ONE  = PW'(1);
    localparam logic [PW-1:0] PEND_ZERO = {PW{1'b0}};
    localparam logic [TW-1:0] TRP_LOAD  = TW'(T_RP - 1);
    localparam logic [TW-1:0] TRFC_LOAD = TW'(T_RFC - 1);
    localparam logic [TW-1:0] TMR_ZERO  = {TW{1'b0}};

    localparam logic [2:0] ST_IDLE     = RS_IDLE;
    localparam logic [2:0] ST_REQ      = RS_REQ;
    localparam logic [2:0] ST_PREA     = RS_PREA;
    localparam logic [2:0] ST_WAIT_RP  = RS_WAIT_RP;
    localparam logic [2:0] ST_REF      = RS_REF;
    localparam logic [2:0] ST_WAIT_RFC = RS_WAIT_RFC;

    logic [2:0]    state_r;
    logic [2:0]    state_next_s;
    logic [PW-1:0] pending_r;
    logic [PW-1:0] pending_next_s;
    logic          overflow_r;
    logic          ovf_set_s;
    logic          ref_req_r;
    logic          ref_busy_r;
    logic          cmd_valid_r;
    logic [1:0]    cmd_code_r;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_val_s;
    logic          tmr_zero_s;
    logic          ref_hs_s;

    assign ref_hs_s = cmd_valid_r & cmd_ready & (cmd_code_r == REF);

    down_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    // Owed-refresh bookkeeping: a tick and a REF handshake together cancel out.
    always_comb begin
        pending_next_s = pending_r;
        ovf_set_s      = 1'b0;
        case ({refresh_flag, ref_hs_s})
            2'b10: begin
                if (pending_r == PEND_SAT) begin
                    ovf_set_s = 1'b1;
                end else begin
                    pending_next_s = pending_r + PEND_ONE;
                end
            end
            2'b01: begin
                if (pending_r != PEND_ZERO) begin
                    pending_next_s = pending_r - PEND_ONE;
                end else begin
                    pending_next_s = pending_r;
                end
            end
            2'b11: begin
                if (pending_r == PEND_SAT) begin
                    ovf_set_s = 1'b1;
                end else begin
                    ovf_set_s = 1'b0;
                end
            end
            default: begin
                pending_next_s = pending_r;
            end
        endcase
    end

    // Refresh sequencing; the grant is only looked at in REQ, so losing it later is ignored.
    always_comb begin
        state_next_s = state_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = TMR_ZERO;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != PEND_ZERO) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ref_gnt) begin
                    state_next_s = ST_PREA;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_PREA: begin
                if (cmd_ready) begin
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = TRP_LOAD;
                    state_next_s = ST_WAIT_RP;
                end else begin
                    state_next_s = ST_PREA;
                end
            end
            ST_WAIT_RP: begin
                if (tmr_zero_s) begin
                    state_next_s = ST_REF;
                end else begin
                    state_next_s = ST_WAIT_RP;
                end
            end
            ST_REF: begin
                if (cmd_ready) begin
                    tmr_load_s   = 1'b1;
                    tmr_val_s    = TRFC_LOAD;
                    state_next_s = ST_WAIT_RFC;
                end else begin
                    state_next_s = ST_REF;
                end
            end
            ST_WAIT_RFC: begin
                if (tmr_zero_s) begin
`ifdef REFRESH_BURST_EN
                    // Banks are still closed, so another owed refresh can go straight to REF.
                    if (pending_r != PEND_ZERO) begin
                        state_next_s = ST_REF;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
`else
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    state_next_s = ST_WAIT_RFC;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, pending count and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pending_r  <= PEND_ZERO;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pending_r  <= pending_next_s;
            overflow_r <= overflow_r | ovf_set_s;
        end
    end

    // Bus outputs are registered from the next state so they switch together with the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_req_r   <= 1'b0;
            ref_busy_r  <= 1'b0;
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= NOP;
        end else begin
            ref_req_r   <= (state_next_s != ST_IDLE);
            ref_busy_r  <= (state_next_s != ST_IDLE);
            cmd_valid_r <= (cmd_for_state(state_next_s) != NOP);
            cmd_code_r  <= cmd_for_state(state_next_s);
        end
    end

    assign ref_req    = ref_req_r;
    assign ref_busy   = ref_busy_r;
    assign cmd_valid  = cmd_valid_r;
    assign cmd_code   = cmd_code_r;
    assign pending    = pending_r;
    assign overflow   = overflow_r;
    assign ref_urgent = (pending_r >= PEND_URG);

endmodule

// File: tb/tb_refresh_scheduler.sv
// Scoreboard bench for refresh_scheduler: expected bus commands (code and cycle) are queued
// when stimulus is driven and compared as the DUT hands them off; state checks are inline.
module tb_refresh_scheduler;
    import dram_pkg::*;

    localparam int MAXP = 8;
    localparam int TRP  = 3;
    localparam int TRFC = 44;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       refresh_flag = 1'b0;
    logic       ref_gnt = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       ref_req;
    logic       ref_urgent;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [3:0] pending;
    logic       ref_busy;
    logic       overflow;

    refresh_scheduler #(
        .MAX_POSTPONE (MAXP),
        .T_RP         (TRP),
        .T_RFC        (TRFC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .refresh_flag (refresh_flag),
        .ref_gnt      (ref_gnt),
        .cmd_ready    (cmd_ready),
        .ref_req      (ref_req),
        .ref_urgent   (ref_urgent),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .pending      (pending),
        .ref_busy     (ref_busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] code;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic expect_cmd(input logic [1:0] code, input int at);
        exp_t e;
        e.code = code;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) nxt();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ref_req"}, 32'(ref_req), 32'd0);
        chk({tag, "_urgent"}, 32'(ref_urgent), 32'd0);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_cmd_code"}, 32'(cmd_code), 32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_busy"}, 32'(ref_busy), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Command monitor: every accepted command must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 32'(cmd_code), 32'd0);
            end else begin
                e_mon = exp_q.pop_front();
                chk("cmd_code", 32'(cmd_code), 32'(e_mon.code));
                chk("cmd_cycle", 32'(cyc), 32'(e_mon.at));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int exp_p;
        int gap;
        int second_ref;

        // Reset state
        repeat (3) nxt();
        chk_all_zero("reset");
        rst = 1'b0;
        nxt();

        // Single refresh with grant and ready tied high
        ref_gnt   = 1'b1;
        cmd_ready = 1'b1;
        t = cyc;
        expect_cmd(PREA, t + 3);
        expect_cmd(REF, t + 3 + TRP + 1);
        refresh_flag = 1'b1;
        nxt();
        refresh_flag = 1'b0;
        chk("t1_pending_up", 32'(pending), 32'd1);
        chk("t1_req_not_yet", 32'(ref_req), 32'd0);
        nxt();
        chk("t1_req_at_2", 32'(ref_req), 32'd1);
        wait_to(t + 8);
        chk("t1_pending_down", 32'(pending), 32'd0);
        wait_to(t + 7 + TRFC);
        chk("t1_busy_in_rfc", 32'(ref_busy), 32'd1);
        nxt();
        chk("t1_idle", 32'(ref_busy), 32'd0);
        chk("t1_req_drop", 32'(ref_req), 32'd0);

        // Postponement: no grant, 10 consecutive ticks
        ref_gnt = 1'b0;
        nxt();
        for (int i = 1; i <= 10; i++) begin
            refresh_flag = 1'b1;
            nxt();
            exp_p = (i > MAXP + 1) ? MAXP + 1 : i;
            chk("t2_pending", 32'(pending), 32'(exp_p));
            chk("t2_urgent", 32'(ref_urgent), (exp_p >= MAXP) ? 32'd1 : 32'd0);
            chk("t2_overflow", 32'(overflow), (i == 10) ? 32'd1 : 32'd0);
        end
        refresh_flag = 1'b0;
        nxt();
        chk("t2_req_held", 32'(ref_req), 32'd1);
        chk("t2_no_cmd", 32'(cmd_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk_all_zero("t2_rst");
        nxt();
        rst = 1'b0;
        nxt();

        // Backpressure: cmd_ready low for 5 cycles during PREA
        ref_gnt   = 1'b1;
        cmd_ready = 1'b0;
        t = cyc;
        refresh_flag = 1'b1;
        nxt();
        refresh_flag = 1'b0;
        wait_to(t + 3);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(cmd_valid), 32'd1);
            chk("t3_hold_code", 32'(cmd_code), 32'd1);
            nxt();
        end
        chk("t3_still_valid", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1;
        expect_cmd(PREA, t + 8);
        expect_cmd(REF, t + 8 + TRP + 1);
        nxt();
        chk("t3_rp_started", 32'(cmd_valid), 32'd0);
        wait_to(t + 8 + TRP);
        chk("t3_rp_end_no_cmd", 32'(cmd_valid), 32'd0);
        wait_to(t + 12 + TRFC + 1);
        chk("t3_idle", 32'(ref_busy), 32'd0);
        chk("t3_pending", 32'(pending), 32'd0);

        // Tick coincident with the REF handshake while pending = 1
        t = cyc;
        expect_cmd(PREA, t + 3);
        expect_cmd(REF, t + 7);
        refresh_flag = 1'b1;
        nxt();
        refresh_flag = 1'b0;
        wait_to(t + 7);
        refresh_flag = 1'b1;
        nxt();
        refresh_flag = 1'b0;
        chk("t4_pending_hold", 32'(pending), 32'd1);
`ifdef REFRESH_BURST_EN
        second_ref = t + 7 + TRFC + 1;
        expect_cmd(REF, second_ref);
`else
        second_ref = t + 7 + TRFC + 1 + 6;
        expect_cmd(PREA, second_ref - TRP - 1);
        expect_cmd(REF, second_ref);
`endif
        wait_to(second_ref + 1);
        chk("t4_pending_after", 32'(pending), 32'd0);
        wait_to(second_ref + TRFC + 1);
        chk("t4_idle", 32'(ref_busy), 32'd0);

        // Reset during WAIT_RFC with three refreshes still owed
        t = cyc;
        expect_cmd(PREA, t + 3);
        expect_cmd(REF, t + 7);
        refresh_flag = 1'b1;
        repeat (4) nxt();
        refresh_flag = 1'b0;
        wait_to(t + 20);
        chk("t5_pending_pre", 32'(pending), 32'd3);
        chk("t5_busy_pre", 32'(ref_busy), 32'd1);
        chk("t5_req_pre", 32'(ref_req), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("t5_async");
        nxt();
        nxt();
        rst = 1'b0;
        nxt();
        nxt();
        chk("t5_idle", 32'(ref_busy), 32'd0);
        chk("t5_pending", 32'(pending), 32'd0);
        chk("t5_req", 32'(ref_req), 32'd0);

`ifdef REFRESH_BURST_EN
        // Burst: one PREA, then three REFs spaced T_RFC+1 apart with ref_req held
        t = cyc;
        expect_cmd(PREA, t + 3);
        expect_cmd(REF, t + 7);
        expect_cmd(REF, t + 7 + (TRFC + 1));
        expect_cmd(REF, t + 7 + 2 * (TRFC + 1));
        refresh_flag = 1'b1;
        repeat (3) nxt();
        refresh_flag = 1'b0;
        gap = 0;
        while (cyc < t + 7 + 2 * (TRFC + 1) + TRFC + 1) begin
            if (!ref_req) gap++;
            nxt();
        end
        chk("t6_req_continuous", 32'(gap), 32'd0);
        chk("t6_idle", 32'(ref_busy), 32'd0);
        chk("t6_pending", 32'(pending), 32'd0);
`else
        gap = 0;
`endif

        repeat (5) nxt();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/refresh_scheduler.md
# refresh_scheduler

Consumes the `refresh_flag` tick from the refresh interval counter and turns each tick into a DRAM refresh operation: arbitration request, precharge-all, refresh, then the tRP and tRFC waits. It sits between the refresh counter and the command arbiter. It tracks postponed refreshes, escalates to urgent when the postpone budget is exhausted, and flags overflow.

## Interface
- `MAX_POSTPONE`, default 8 — refreshes that may be owed before `ref_urgent`.
- `T_RP`, default 3 — cycles from the PREA handshake to the REF issue.
- `T_RFC`, default 44 — cycles from the REF handshake until the bank group is usable.
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `refresh_flag`  in  1  — one-cycle tick from the refresh counter; each high cycle equals one owed refresh.
- `ref_gnt`  in  1  — arbiter grant; the scheduler owns the command bus while it holds `ref_req`.
- `cmd_ready`  in  1  — command bus accepts `cmd_code` this cycle.
- `ref_req`  out  1  — request for command-bus ownership.
- `ref_urgent`  out  1  — pending count is at least `MAX_POSTPONE`; the arbiter must grant next.
- `cmd_valid`  out  1  — `cmd_code` is valid.
- `cmd_code`  out  2  — command code: 2'b01 = PREA, 2'b10 = REF.
- `pending`  out  `$clog2(MAX_POSTPONE+2)`  — number of owed refreshes.
- `ref_busy`  out  1  — high in every state except IDLE.
- `overflow`  out  1  — sticky; set when a tick arrives with `pending == MAX_POSTPONE+1`.

## Operation
- **Reset values:** every output is 0; state is IDLE; `pending` and the timer are 0.
- **Pending counter:**
  - +1 on `refresh_flag`.
  - −1 on a REF handshake (`cmd_valid & cmd_ready & cmd_code==REF`).
  - Both in the same cycle: no net change.
  - Saturates at `MAX_POSTPONE+1`. A tick at saturation sets `overflow` and is dropped.
- **`ref_urgent`:** combinational, `pending >= MAX_POSTPONE`.
- **FSM states:** IDLE, REQ, PREA, WAIT_RP, REF, WAIT_RFC.
  - IDLE → REQ when `pending != 0`.
  - REQ: `ref_req` = 1. → PREA on `ref_gnt`.
  - PREA: `cmd_valid` = 1, `cmd_code` = 01. On `cmd_ready`: load timer with `T_RP-1`, go to WAIT_RP.
  - WAIT_RP: timer counts down. At 0 → REF.
  - REF: `cmd_valid` = 1, `cmd_code` = 10. On `cmd_ready`: load timer with `T_RFC-1`, go to WAIT_RFC.
  - WAIT_RFC: at timer 0 → IDLE. `ref_req` drops on entry to IDLE.
- **Bus ownership:** `ref_req` stays high in states REQ through WAIT_RFC.
- **Command hold:** `cmd_valid` and `cmd_code` stay stable until `cmd_ready`; no withdrawal.
- **Grant loss:** `ref_gnt` deasserting after it was granted is ignored. Ownership is held until the sequence ends.
- **Timer:** `$clog2(T_RFC)` bits; never underflows.
- **Reset mid-sequence:** abort immediately. All outputs return to 0, owed refreshes are discarded, `overflow` is cleared.

## Timing
- Tick sampled at edge N → `pending` updated at N+1 → `ref_req` high from N+2, when the FSM was idle.
- `ref_gnt` sampled at edge M → `cmd_valid` (PREA) high from M+1.
- PREA accepted at edge P → REF `cmd_valid` high from P+`T_RP`+1.
- REF accepted at edge R → state IDLE at R+`T_RFC`+1. The next REQ can start at R+`T_RFC`+2 if `pending` is still nonzero.
- Minimum refresh turnaround with `cmd_ready` tied high: `T_RP`+`T_RFC`+4 cycles.

## Configuration
- Macro: `REFRESH_BURST_EN`.
- **Defined:** at the end of WAIT_RFC, if `pending != 0`, go directly to REF.
  - Banks are still closed, so PREA and REQ are skipped.
  - `ref_req` stays high across the burst.
  - Back-to-back REF spacing is `T_RFC`+1 cycles.
- **Undefined:** every refresh runs the full IDLE→REQ→PREA sequence.

## Structure
- Shared package `dram_pkg` holds:
  - `cmd_t` enum: NOP = 00, PREA = 01, REF = 10.
  - `ref_state_t` FSM enum.
  - Default timing constants `T_RP_DEF` and `T_RFC_DEF`.
- One sub-module: `down_timer`, a loadable down-counter with a `zero` output. It is used for both the tRP and tRFC waits.

## Test plan
- **Single refresh:** reset, one tick, `ref_gnt` and `cmd_ready` tied high. Expect `ref_req` at +2, PREA then REF exactly `T_RP`+1 cycles apart, `pending` 1→0, IDLE after `T_RFC`+1.
- **Postponement:** withhold `ref_gnt` for 9 ticks. Expect `ref_urgent` when `pending` = 8, `pending` = 9, `overflow` = 0. A 10th tick gives `pending` = 9 and `overflow` = 1.
- **Backpressure:** hold `cmd_ready` low for 5 cycles during PREA. Expect `cmd_valid` and `cmd_code` = 01 stable throughout, and the tRP count starting only after the handshake.
- **Simultaneous events:** tick in the same cycle as the REF handshake with `pending` = 1. Expect `pending` stays 1 and a second sequence follows.
- **Reset mid-sequence:** assert `rst` during WAIT_RFC with `pending` = 3. Expect all outputs 0 asynchronously and IDLE after release.
- **Burst mode (`REFRESH_BURST_EN`):** `pending` = 3. Expect one PREA then three REFs spaced `T_RFC`+1 cycles, with `ref_req` continuously high.
